// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader for the byte-wide instruction memory.
// Optional readback check after a good checksum: define IMEM_LOADER_READBACK_EN.
module imem_loader #(
  parameter int ADDR_BUS_WIDTH = 16,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      mem_we,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata,
  output logic                      cpu_stall,
  output logic                      done,
  output logic                      error
);

  typedef enum logic [3:0] {
    IDLE,
    HDR_A1,
    HDR_A0,
    HDR_L1,
    HDR_L0,
    DATA,
    CSUM,
    VERIFY,
    FIN_OK,
    FIN_ERR
  } state_t;

  state_t state;
  state_t nxt;

  logic                      acc;
  logic [7:0]                hi;
  logic [7:0]                sum;
  logic [ADDR_BUS_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]      count;
  logic [ADDR_BUS_WIDTH-1:0] hdr_addr;
  logic [LEN_WIDTH-1:0]      hdr_len;

  // header fields arrive big-endian; width casts truncate or extend
  assign hdr_addr = ADDR_BUS_WIDTH'({hi, in_data});
  assign hdr_len  = LEN_WIDTH'({hi, in_data});
  assign acc      = in_valid & in_ready;

`ifdef IMEM_LOADER_READBACK_EN
  logic [ADDR_BUS_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0]      len;
  logic [7:0]                rsum;
  logic [7:0]                rsum_nx;

  assign rsum_nx = rsum + mem_rdata;
`else
  logic unused_rdata;

  assign unused_rdata = ^mem_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) nxt = HDR_A1;
      end
      HDR_A1: begin
        if (acc) nxt = HDR_A0;
      end
      HDR_A0: begin
        if (acc) nxt = HDR_L1;
      end
      HDR_L1: begin
        if (acc) nxt = HDR_L0;
      end
      HDR_L0: begin
        if (acc) begin
          if (hdr_len == '0) nxt = CSUM;
          else nxt = DATA;
        end
      end
      DATA: begin
        if (acc && count == LEN_WIDTH'(1)) nxt = CSUM;
      end
      CSUM: begin
        if (acc) begin
          if (in_data != sum) nxt = FIN_ERR;
`ifdef IMEM_LOADER_READBACK_EN
          else if (len != '0) nxt = VERIFY;
`endif
          else nxt = FIN_OK;
        end
      end
      VERIFY: begin
`ifdef IMEM_LOADER_READBACK_EN
        if (count == LEN_WIDTH'(1)) begin
          if (rsum_nx == sum) nxt = FIN_OK;
          else nxt = FIN_ERR;
        end
`else
        nxt = IDLE;
`endif
      end
      FIN_OK:  nxt = IDLE;
      FIN_ERR: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      HDR_A1, HDR_A0,
      HDR_L1, HDR_L0,
      DATA, CSUM: in_ready = 1'b1;
      default:    in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_stall <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      hi        <= '0;
      sum       <= '0;
      addr      <= '0;
      count     <= '0;
`ifdef IMEM_LOADER_READBACK_EN
      base      <= '0;
      len       <= '0;
      rsum      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            sum       <= '0;
            cpu_stall <= 1'b1;
          end
        end
        (state == HDR_A1): begin
          if (acc) hi <= in_data;
        end
        (state == HDR_A0): begin
          if (acc) begin
            addr <= hdr_addr;
`ifdef IMEM_LOADER_READBACK_EN
            base <= hdr_addr;
`endif
          end
        end
        (state == HDR_L1): begin
          if (acc) hi <= in_data;
        end
        (state == HDR_L0): begin
          if (acc) begin
            count <= hdr_len;
`ifdef IMEM_LOADER_READBACK_EN
            len   <= hdr_len;
`endif
          end
        end
        (state == DATA): begin
          // write lands one cycle after the accept
          if (acc) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= in_data;
            sum       <= sum + in_data;
            addr      <= addr + 1'b1;
            count     <= count - 1'b1;
          end
        end
`ifdef IMEM_LOADER_READBACK_EN
        (state == CSUM): begin
          if (acc) begin
            mem_addr <= base;
            count    <= len;
            rsum     <= '0;
          end
        end
        (state == VERIFY): begin
          rsum     <= rsum_nx;
          mem_addr <= mem_addr + 1'b1;
          count    <= count - 1'b1;
        end
`endif
        (state == FIN_OK): begin
          done      <= 1'b1;
          cpu_stall <= 1'b0;
        end
        (state == FIN_ERR): begin
          error     <= 1'b1;
          cpu_stall <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames against a frame-level reference model.
// Define IMEM_LOADER_READBACK_EN to exercise the readback verify path.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        cpu_stall;
  logic        done;
  logic        error;

  imem_loader #(
    .ADDR_BUS_WIDTH(16),
    .LEN_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cpu_stall(cpu_stall),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] mem [0:65535];
  logic [7:0] pl[$];
  bit         corrupt_on = 1'b0;

  // instruction memory model; corruption flips the byte at address 5
  assign mem_rdata = mem[mem_addr] ^
    ((corrupt_on && mem_addr == 16'h0005) ? 8'hFF : 8'h00);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wq.push_back('{mem_addr, mem_wdata, cyc});
      mem[mem_addr] <= mem_wdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int gap_of(input int gm);
    if (gm == 0) return 0;
    if (gm == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic send(input logic [7:0] b, input int gap, input bit with_start);
    int n;
    bit r;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data = b;
    start = with_start;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    if (!r) chk("accept_timeout", 0, 1);
  endtask

  task automatic pulse_start(input logic [7:0] first);
    in_valid = 1'b1;
    in_data = first;
    start = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("stall_on", cpu_stall, 1);
    chk("done_clr", done, 0);
    chk("err_clr", error, 0);
  endtask

  task automatic run_frame(input logic [15:0] a, input int cs, input int gm,
                           input bit mid_start, input bit corrupt);
    int          len;
    logic [15:0] l16;
    logic [7:0]  s;
    logic [7:0]  c;
    bit          ok;
    int          wb;
    int          n;
    bit          fin;
    len = pl.size();
    l16 = 16'(len);
    s = 8'h00;
    foreach (pl[i]) s = s + pl[i];
    c = (cs < 0) ? s : 8'(cs);
    ok = (c == s);
`ifdef IMEM_LOADER_READBACK_EN
    if (corrupt && len != 0) ok = 1'b0;
`endif
    wb = wq.size();
    pulse_start(a[15:8]);
    send(a[15:8], gap_of(gm), 1'b0);
    send(a[7:0], gap_of(gm), 1'b0);
    send(l16[15:8], gap_of(gm), 1'b0);
    send(l16[7:0], gap_of(gm), 1'b0);
    for (int i = 0; i < len; i++) begin
      send(pl[i], gap_of(gm), mid_start && i == 1);
    end
    send(c, gap_of(gm), 1'b0);
    if (corrupt) corrupt_on = 1'b1;
    chk("stall_fin", cpu_stall, 1);
    n = 0;
    fin = 1'b0;
    while (!fin && n < 200) begin
      @(negedge clk);
      n++;
      fin = done | error;
    end
    chk("fin_seen", fin, 1);
`ifndef IMEM_LOADER_READBACK_EN
    chk("fin_latency", n, 2);
`endif
    chk("done", done, ok);
    chk("error", error, !ok);
    chk("stall_off", cpu_stall, 0);
    chk("ready_idle", in_ready, 0);
    chk("wr_count", wq.size() - wb, len);
    for (int i = 0; i < len && wb + i < wq.size(); i++) begin
      chk("wr_addr", wq[wb+i].a, 16'(a + 16'(i)));
      chk("wr_data", wq[wb+i].d, pl[i]);
      if (gm == 0 && i > 0) chk("wr_b2b", wq[wb+i].c - wq[wb+i-1].c, 1);
    end
    corrupt_on = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
  endtask

  initial begin
    #3;
    chk_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    pl = '{8'hFF, 8'hC4, 8'hA3, 8'h03};
    run_frame(16'h0004, -1, 0, 1'b0, 1'b0);
    run_frame(16'h0004, 8'h00, 0, 1'b0, 1'b0);

    pl = '{8'h11, 8'h22, 8'h33};
    run_frame(16'hFFFE, 8'h66, 0, 1'b0, 1'b0);
    pl = '{};
    run_frame(16'h0010, 8'h00, 0, 1'b0, 1'b0);

    pl = '{8'h5A, 8'h01, 8'h80, 8'h7F, 8'hEE};
    run_frame(16'h0100, -1, 1, 1'b0, 1'b0);
    run_frame(16'h0200, -1, 0, 1'b1, 1'b0);

    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start(8'h00);
    send(8'h00, 0, 1'b0);
    send(8'h04, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'h04, 0, 1'b0);
    send(8'h11, 0, 1'b0);
    send(8'h22, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(16'h0004, -1, 2, 1'b0, 1'b0);

`ifdef IMEM_LOADER_READBACK_EN
    pl = '{8'hFF, 8'hC4, 8'hA3, 8'h03};
    run_frame(16'h0004, -1, 0, 1'b0, 1'b1);
`endif

    for (int k = 0; k < 8; k++) begin
      int ln;
      int cs;
      ln = int'($urandom_range(0, 10));
      pl = '{};
      for (int i = 0; i < ln; i++) pl.push_back(8'($urandom));
      cs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
      run_frame(16'($urandom), cs, int'($urandom_range(0, 2)),
                k[0], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
